// File: rtl/rd_mst_arbiter.sv
// Round-robin sharing of one AXI read master and its return stream between the
// IFM and WGT buffer requesters of conv_engine.
module rd_mst_arbiter #(
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 64,
   parameter int BEAT_CNT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ifm_req,
   input  logic [ADDR_WIDTH-1:0] ifm_addr,
   input  logic [ADDR_WIDTH-1:0] ifm_size,
   output logic                  ifm_done,
   input  logic                  wgt_req,
   input  logic [ADDR_WIDTH-1:0] wgt_addr,
   input  logic [ADDR_WIDTH-1:0] wgt_size,
   output logic                  wgt_done,
   output logic                  rmst_start,
   output logic [ADDR_WIDTH-1:0] rmst_addr,
   output logic [ADDR_WIDTH-1:0] rmst_size,
   input  logic                  rmst_done,
   input  logic                  axis_rmst_tvalid,
   input  logic [DATA_WIDTH-1:0] axis_rmst_tdata,
   output logic                  axis_rmst_tready,
   output logic                  axis_ifm_tvalid,
   output logic [DATA_WIDTH-1:0] axis_ifm_tdata,
   input  logic                  axis_ifm_tready,
   output logic                  axis_wgt_tvalid,
   output logic [DATA_WIDTH-1:0] axis_wgt_tdata,
   input  logic                  axis_wgt_tready,
   output logic                  grant_id,
   output logic                  busy
);
   // state | meaning
   // IDLE  | no transfer; arbitrate between pending requests
   // ISSUE | one-cycle start pulse to the read master
   // XFER  | steer beats to the granted buffer, wait for all beats and rmst_done
   // DONE  | one-cycle done pulse to the granted buffer
   typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int BEAT_SHIFT = $clog2(BYTES);
   localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = ADDR_WIDTH'(BYTES - 1);

   state_t                    state_q, state_d;
   logic                      grant_q, grant_d;
   logic                      last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]     size_q, size_d;
   logic [BEAT_CNT_WIDTH-1:0] exp_beats_q, exp_beats_d;
   logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic                      done_seen_q, done_seen_d;

   logic                      pick;
   logic [ADDR_WIDTH-1:0]     req_size;
   logic [ADDR_WIDTH-1:0]     beats_full;
   logic [BEAT_CNT_WIDTH-1:0] beat_cnt_inc;
   logic                      in_xfer, beats_left, ds_tready, xfer_hs, done_any;

   always_comb begin
      in_xfer          = (state_q == XFER);
      beats_left       = (beat_cnt_q < exp_beats_q);
      ds_tready        = grant_q ? axis_wgt_tready : axis_ifm_tready;
      axis_rmst_tready = in_xfer & ds_tready & beats_left;
      axis_ifm_tvalid  = in_xfer & ~grant_q & axis_rmst_tvalid & beats_left;
      axis_wgt_tvalid  = in_xfer & grant_q & axis_rmst_tvalid & beats_left;
      axis_ifm_tdata   = axis_rmst_tdata;
      axis_wgt_tdata   = axis_rmst_tdata;
      xfer_hs          = axis_rmst_tvalid & axis_rmst_tready;
      beat_cnt_inc     = beat_cnt_q + BEAT_CNT_WIDTH'(xfer_hs);
      done_any         = done_seen_q | rmst_done;

      // Tie goes to whoever was not served last; single requester always wins.
      pick       = (ifm_req & wgt_req) ? ~last_grant_q : wgt_req;
      req_size   = pick ? wgt_size : ifm_size;
      // Shift plus remainder test instead of add-then-shift so sizes near the
      // top of the address range cannot wrap.
      beats_full = (req_size >> BEAT_SHIFT) + ADDR_WIDTH'((req_size & BYTE_MASK) != '0);
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      size_d       = size_q;
      exp_beats_d  = exp_beats_q;
      beat_cnt_d   = beat_cnt_q;
      done_seen_d  = done_seen_q;
      unique case (state_q)
         IDLE: begin
            if (ifm_req | wgt_req) begin
               grant_d     = pick;
               addr_d      = pick ? wgt_addr : ifm_addr;
               size_d      = req_size;
               exp_beats_d = BEAT_CNT_WIDTH'(beats_full);
               state_d     = (req_size == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            done_seen_d = done_any;
            state_d     = XFER;
         end
         XFER: begin
            beat_cnt_d  = beat_cnt_inc;
            done_seen_d = done_any;
            if (done_any && (beat_cnt_inc == exp_beats_q)) state_d = DONE;
         end
         DONE: begin
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            done_seen_d  = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         size_q       <= '0;
         exp_beats_q  <= '0;
         beat_cnt_q   <= '0;
         done_seen_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         exp_beats_q  <= exp_beats_d;
         beat_cnt_q   <= beat_cnt_d;
         done_seen_q  <= done_seen_d;
      end
   end

   assign rmst_start = (state_q == ISSUE);
   assign ifm_done   = (state_q == DONE) & ~grant_q;
   assign wgt_done   = (state_q == DONE) & grant_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;
   assign rmst_addr  = addr_q;
   assign rmst_size  = size_q;

endmodule

// File: tb/tb_rd_mst_arbiter.sv
// Bench for rd_mst_arbiter: scenario tasks drive requests and beats, a negedge
// monitor pops the beat scoreboard as beats leave on the IFM/WGT streams.
module tb_rd_mst_arbiter;
   localparam int DW = 512;
   localparam int AW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ifm_req, wgt_req;
   logic [AW-1:0] ifm_addr, ifm_size, wgt_addr, wgt_size;
   logic          ifm_done, wgt_done;
   logic          rmst_start;
   logic [AW-1:0] rmst_addr, rmst_size;
   logic          rmst_done;
   logic          axis_rmst_tvalid, axis_rmst_tready;
   logic [DW-1:0] axis_rmst_tdata;
   logic          axis_ifm_tvalid, axis_ifm_tready;
   logic [DW-1:0] axis_ifm_tdata;
   logic          axis_wgt_tvalid, axis_wgt_tready;
   logic [DW-1:0] axis_wgt_tdata;
   logic          grant_id, busy;

   logic [DW:0]   exp_q[$];
   int            n_cmp = 0, n_fail = 0;
   int            ifm_done_cnt = 0, wgt_done_cnt = 0, start_cnt = 0;
   logic          ifm_done_prev = 1'b0, wgt_done_prev = 1'b0, start_prev = 1'b0;

   always #5 clk = ~clk;

   rd_mst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEAT_CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifm_req(ifm_req), .ifm_addr(ifm_addr), .ifm_size(ifm_size), .ifm_done(ifm_done),
      .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_size(wgt_size), .wgt_done(wgt_done),
      .rmst_start(rmst_start), .rmst_addr(rmst_addr), .rmst_size(rmst_size), .rmst_done(rmst_done),
      .axis_rmst_tvalid(axis_rmst_tvalid), .axis_rmst_tdata(axis_rmst_tdata),
      .axis_rmst_tready(axis_rmst_tready),
      .axis_ifm_tvalid(axis_ifm_tvalid), .axis_ifm_tdata(axis_ifm_tdata),
      .axis_ifm_tready(axis_ifm_tready),
      .axis_wgt_tvalid(axis_wgt_tvalid), .axis_wgt_tdata(axis_wgt_tdata),
      .axis_wgt_tready(axis_wgt_tready),
      .grant_id(grant_id), .busy(busy)
   );

   function automatic logic [DW-1:0] mk_data(input logic [15:0] tag, input logic [15:0] idx);
      mk_data = {16{tag, idx}};
   endfunction

   // Scoreboard consumer and pulse-shape monitor.
   always @(negedge clk) begin
      logic [DW:0] e;
      if (ifm_done) ifm_done_cnt++;
      if (wgt_done) wgt_done_cnt++;
      if (rmst_start) start_cnt++;
      if (ifm_done || wgt_done || rmst_start) begin
         n_cmp++;
         if ((ifm_done && wgt_done) || (ifm_done && ifm_done_prev) ||
             (wgt_done && wgt_done_prev) || (rmst_start && start_prev)) begin
            n_fail++;
            $display("FAIL pulse_shape: ifm_done=%0b(prev %0b) wgt_done=%0b(prev %0b) start=%0b(prev %0b), required single-cycle exclusive pulses",
                     ifm_done, ifm_done_prev, wgt_done, wgt_done_prev, rmst_start, start_prev);
         end
      end
      ifm_done_prev = ifm_done;
      wgt_done_prev = wgt_done;
      start_prev    = rmst_start;
      if (axis_ifm_tvalid && axis_ifm_tready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ifm_beat: got unexpected beat %h, required none", axis_ifm_tdata[31:0]);
         end else begin
            e = exp_q.pop_front();
            if (e !== {1'b0, axis_ifm_tdata}) begin
               n_fail++;
               $display("FAIL ifm_beat: got dest 0 data %h, required dest %0b data %h",
                        axis_ifm_tdata[31:0], e[DW], e[31:0]);
            end
         end
      end
      if (axis_wgt_tvalid && axis_wgt_tready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wgt_beat: got unexpected beat %h, required none", axis_wgt_tdata[31:0]);
         end else begin
            e = exp_q.pop_front();
            if (e !== {1'b1, axis_wgt_tdata}) begin
               n_fail++;
               $display("FAIL wgt_beat: got dest 1 data %h, required dest %0b data %h",
                        axis_wgt_tdata[31:0], e[DW], e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifm_req = 1'b0; wgt_req = 1'b0;
      ifm_addr = '0; ifm_size = '0; wgt_addr = '0; wgt_size = '0;
      rmst_done = 1'b0; axis_rmst_tvalid = 1'b0; axis_rmst_tdata = '0;
      axis_ifm_tready = 1'b1; axis_wgt_tready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_start(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!rmst_start && cyc < 20) begin
         tick();
         @(negedge clk);
         cyc++;
      end
   endtask

   // Offers beats first..first+n-1 back to back, holding each until accepted.
   task automatic push_beats(input logic dest, input logic [15:0] tag, input int first, input int n);
      int   idx = first;
      int   cyc = 0;
      logic offered = 1'b0;
      logic acc;
      while (idx < first + n && cyc < 50) begin
         axis_rmst_tvalid = 1'b1;
         axis_rmst_tdata  = mk_data(tag, 16'(idx));
         if (!offered) begin
            exp_q.push_back({dest, axis_rmst_tdata});
            offered = 1'b1;
         end
         @(negedge clk);
         acc = axis_rmst_tready;
         n_cmp++;
         if ((dest ? axis_ifm_tvalid : axis_wgt_tvalid) !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stream_valid: non-granted tvalid=1, required 0 (dest %0b)", dest);
         end
         tick();
         if (acc) begin
            idx++;
            offered = 1'b0;
         end
         cyc++;
      end
      axis_rmst_tvalid = 1'b0;
      n_cmp++;
      if (idx != first + n) begin
         n_fail++;
         $display("FAIL beat_timeout: accepted %0d beats, required %0d", idx - first, n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++;
      if ({rmst_start, ifm_done, wgt_done, axis_rmst_tready, axis_ifm_tvalid,
           axis_wgt_tvalid, grant_id, busy} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: start=%0b idone=%0b wdone=%0b rdy=%0b iv=%0b wv=%0b gid=%0b busy=%0b, required all 0",
                  rmst_start, ifm_done, wgt_done, axis_rmst_tready, axis_ifm_tvalid,
                  axis_wgt_tvalid, grant_id, busy);
      end
      n_cmp++;
      if (rmst_addr !== '0 || rmst_size !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: addr=%h size=%h, required 0", rmst_addr, rmst_size);
      end
      tick();
   endtask

   task automatic test_single_ifm();
      int d0 = ifm_done_cnt;
      int w0 = wgt_done_cnt;
      ifm_addr = 64'h1000; ifm_size = 64'd256; ifm_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rmst_start !== 1'b0) begin
         n_fail++; $display("FAIL start_early: rmst_start=%0b, required 0", rmst_start);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (rmst_start !== 1'b1) begin
         n_fail++; $display("FAIL start_latency: rmst_start=%0b, required 1", rmst_start);
      end
      n_cmp++;
      if (rmst_addr !== 64'h1000 || rmst_size !== 64'd256 || grant_id !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_regs: addr=%h size=%0d gid=%0b busy=%0b, required 1000 256 0 1",
                  rmst_addr, rmst_size, grant_id, busy);
      end
      tick();
      push_beats(1'b0, 16'h1F00, 0, 4);
      tick();
      rmst_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ifm_done_cnt != d0) begin
         n_fail++; $display("FAIL done_before_rmst_done: %0d pulses, required 0", ifm_done_cnt - d0);
      end
      tick();
      rmst_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ifm_done !== 1'b1) begin
         n_fail++; $display("FAIL ifm_done_timing: ifm_done=%0b, required 1", ifm_done);
      end
      tick();
      ifm_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ifm_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL after_done: ifm_done=%0b busy=%0b, required 0 0", ifm_done, busy);
      end
      n_cmp++;
      if (ifm_done_cnt != d0 + 1 || wgt_done_cnt != w0) begin
         n_fail++;
         $display("FAIL single_done_count: ifm %0d wgt %0d, required 1 0", ifm_done_cnt - d0, wgt_done_cnt - w0);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int   cyc;
      logic exp_id;
      do_reset();
      tick();
      for (int g = 0; g < 4; g++) begin
         exp_id = g[0];
         if (g == 0 || g == 2) begin
            ifm_addr = 64'h2000 + 64'(g * 'h100); wgt_addr = 64'h3000 + 64'(g * 'h100);
            ifm_size = 64'd64; wgt_size = 64'd64;
            ifm_req = 1'b1; wgt_req = 1'b1;
         end
         wait_start(cyc);
         n_cmp++;
         if (rmst_start !== 1'b1 || grant_id !== exp_id) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: start=%0b gid=%0b, required 1 %0b", g, rmst_start, grant_id, exp_id);
         end
         n_cmp++;
         if (rmst_addr !== (exp_id ? wgt_addr : ifm_addr)) begin
            n_fail++; $display("FAIL rr_addr[%0d]: addr=%h, required %h", g, rmst_addr,
                               exp_id ? wgt_addr : ifm_addr);
         end
         tick();
         push_beats(exp_id, 16'h2A00 + 16'(g), 0, 1);
         rmst_done = 1'b1;
         tick();
         rmst_done = 1'b0;
         @(negedge clk);
         n_cmp++;
         if ((exp_id ? wgt_done : ifm_done) !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_done[%0d]: ifm_done=%0b wgt_done=%0b, required grant %0b done",
                     g, ifm_done, wgt_done, exp_id);
         end
         tick();
         if (exp_id) wgt_req = 1'b0;
         else        ifm_req = 1'b0;
         tick();
      end
   endtask

   task automatic test_early_done();
      int cyc;
      int d0 = ifm_done_cnt;
      ifm_addr = 64'h4000; ifm_size = 64'd100; ifm_req = 1'b1;
      wait_start(cyc);
      n_cmp++;
      if (rmst_size !== 64'd100) begin
         n_fail++; $display("FAIL early_size: size=%0d, required 100", rmst_size);
      end
      tick();
      push_beats(1'b0, 16'h4400, 0, 1);
      rmst_done = 1'b1;
      tick();
      rmst_done = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (ifm_done_cnt != d0) begin
         n_fail++; $display("FAIL early_premature: %0d done pulses before last beat, required 0", ifm_done_cnt - d0);
      end
      push_beats(1'b0, 16'h4400, 1, 1);
      @(negedge clk);
      n_cmp++;
      if (ifm_done !== 1'b1) begin
         n_fail++; $display("FAIL early_done_timing: ifm_done=%0b, required 1", ifm_done);
      end
      tick();
      ifm_req = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if (ifm_done_cnt != d0 + 1) begin
         n_fail++; $display("FAIL early_done_count: %0d pulses, required 1", ifm_done_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int         cyc;
      int         idx = 0;
      logic       offered = 1'b0;
      logic       exp_rdy;
      logic [3:0] rdy_pat = 4'b1001;
      axis_wgt_tready = 1'b0;
      wgt_addr = 64'h5000; wgt_size = 64'd192; wgt_req = 1'b1;
      wait_start(cyc);
      tick();
      for (int c = 0; c < 8; c++) begin
         axis_wgt_tready  = (c < 4) ? rdy_pat[c] : 1'b1;
         axis_rmst_tvalid = 1'b1;
         axis_rmst_tdata  = mk_data(16'h5500, 16'(idx));
         if (!offered && idx < 3) begin
            exp_q.push_back({1'b1, axis_rmst_tdata});
            offered = 1'b1;
         end
         @(negedge clk);
         exp_rdy = axis_wgt_tready && (idx < 3);
         n_cmp++;
         if (axis_rmst_tready !== exp_rdy || axis_wgt_tvalid !== (idx < 3) || axis_ifm_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_cycle[%0d]: rdy=%0b wv=%0b iv=%0b, required %0b %0b 0",
                     c, axis_rmst_tready, axis_wgt_tvalid, axis_ifm_tvalid, exp_rdy, idx < 3);
         end
         tick();
         if (exp_rdy) begin
            idx++;
            offered = 1'b0;
         end
      end
      rmst_done = 1'b1;
      tick();
      rmst_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (wgt_done !== 1'b1 || axis_rmst_tready !== 1'b0) begin
         n_fail++; $display("FAIL bp_done: wgt_done=%0b rdy=%0b, required 1 0", wgt_done, axis_rmst_tready);
      end
      tick();
      wgt_req = 1'b0;
      axis_rmst_tvalid = 1'b0;
      axis_wgt_tready = 1'b1;
      tick();
   endtask

   task automatic test_zero_size();
      int s0 = start_cnt;
      int w0 = wgt_done_cnt;
      wgt_addr = 64'h6000; wgt_size = 64'd0; wgt_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_busy_pre: busy=%0b, required 0", busy);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (wgt_done !== 1'b1 || busy !== 1'b1 || grant_id !== 1'b1 || rmst_size !== '0) begin
         n_fail++;
         $display("FAIL zero_done: wgt_done=%0b busy=%0b gid=%0b size=%0d, required 1 1 1 0",
                  wgt_done, busy, grant_id, rmst_size);
      end
      tick();
      wgt_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (wgt_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_after: wgt_done=%0b busy=%0b, required 0 0", wgt_done, busy);
      end
      tick(); tick();
      n_cmp++;
      if (start_cnt != s0 || wgt_done_cnt != w0 + 1) begin
         n_fail++;
         $display("FAIL zero_counts: starts %0d dones %0d, required 0 1", start_cnt - s0, wgt_done_cnt - w0);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int d0 = ifm_done_cnt;
      int w0 = wgt_done_cnt;
      ifm_addr = 64'h7000; ifm_size = 64'd256; ifm_req = 1'b1;
      wait_start(cyc);
      tick();
      push_beats(1'b0, 16'h7700, 0, 2);
      rst_n = 1'b0;
      ifm_req = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rmst_start, ifm_done, wgt_done, axis_rmst_tready, axis_ifm_tvalid,
           axis_wgt_tvalid, grant_id, busy} !== 8'b0 || rmst_addr !== '0 || rmst_size !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: start=%0b idone=%0b rdy=%0b gid=%0b busy=%0b addr=%h, required all 0",
                  rmst_start, ifm_done, axis_rmst_tready, grant_id, busy, rmst_addr);
      end
      tick(); tick(); tick();
      n_cmp++;
      if (ifm_done_cnt != d0 || wgt_done_cnt != w0) begin
         n_fail++; $display("FAIL midreset_no_done: %0d pulses, required 0", ifm_done_cnt - d0 + wgt_done_cnt - w0);
      end
      ifm_addr = 64'h8000; ifm_size = 64'd128; ifm_req = 1'b1;
      wait_start(cyc);
      n_cmp++;
      if (cyc != 1 || rmst_addr !== 64'h8000 || grant_id !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_regrant: latency=%0d addr=%h gid=%0b, required 1 8000 0", cyc, rmst_addr, grant_id);
      end
      tick();
      push_beats(1'b0, 16'h8800, 0, 2);
      rmst_done = 1'b1;
      tick();
      rmst_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ifm_done !== 1'b1) begin
         n_fail++; $display("FAIL midreset_fresh_done: ifm_done=%0b, required 1", ifm_done);
      end
      tick();
      ifm_req = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_ifm();
      test_round_robin();
      test_early_done();
      test_backpressure();
      test_zero_size();
      test_reset_mid();
      tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d beats never delivered, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
